// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, special
// instruction words and register-field helpers.
package pipeline_sequencer_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned DRAIN_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seqState_t;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [INSTR_W-1:0] NOP        = 32'h0000_0000;

    function automatic logic [REG_ADDR_W-1:0] rsOf(input logic [INSTR_W-1:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rtOf(input logic [INSTR_W-1:0] instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard detection: a load in execute whose destination is a
// source of the instruction in decode.
module hazard_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rsD,
    input  logic [REG_ADDR_W-1:0] rtD,
    input  logic                  mem_to_reg_writeE,
    input  logic [REG_ADDR_W-1:0] write_reg_addrE,
    output logic                  loadUse_c
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        loadUse_c = mem_to_reg_writeE
                    && (write_reg_addrE != '0)
                    && ((write_reg_addrE == rsD) || (write_reg_addrE == rtD));
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: branch/load-use handling, halt-and-drain FSM,
// and cycle/stall counters, all clocked on the falling edge.
module pipeline_sequencer
    import pipeline_sequencer_pkg::seqState_t, pipeline_sequencer_pkg::RUN,
           pipeline_sequencer_pkg::DRAIN, pipeline_sequencer_pkg::HALTED,
           pipeline_sequencer_pkg::INSTR_W, pipeline_sequencer_pkg::REG_ADDR_W,
           pipeline_sequencer_pkg::DRAIN_CNT_W, pipeline_sequencer_pkg::rsOf,
           pipeline_sequencer_pkg::rtOf;
#(
    parameter logic [31:0] HALT_INSTR   = pipeline_sequencer_pkg::HALT_INSTR,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    instrD,
    input  logic                  mem_to_reg_writeE,
    input  logic [REG_ADDR_W-1:0] write_reg_addrE,
    input  logic                  branch_takenE,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  pc_selF,
    output logic                  halted,
    output logic [31:0]           cycle_count,
    output logic [15:0]           stall_count
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    seqState_t              state;
    seqState_t              stateNext;
    logic [DRAIN_CNT_W-1:0] drainCnt;
    logic [DRAIN_CNT_W-1:0] drainCntNext;
    logic                   stallInc;
    logic                   loadUse;

    hazard_detect uHazard (
        .rsD               (rsOf(instrD)),
        .rtD               (rtOf(instrD)),
        .mem_to_reg_writeE (mem_to_reg_writeE),
        .write_reg_addrE   (write_reg_addrE),
        .loadUse_c         (loadUse)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            drainCnt <= '0;
        end else begin
            state    <= stateNext;
            drainCnt <= drainCntNext;
        end
    end

    // Next state and pipeline controls; HALTED drives constants so its outputs never see the inputs.
    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        stallInc     = 1'b0;
        stallF       = 1'b0;
        stallD       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        pc_selF      = 1'b0;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (branch_takenE) begin
                    pc_selF = 1'b1;
                    flushD  = 1'b1;
                    flushE  = 1'b1;
                end else if (loadUse) begin
                    stallF   = 1'b1;
                    stallD   = 1'b1;
                    flushE   = 1'b1;
                    stallInc = 1'b1;
                end else if (instrD == HALT_INSTR) begin
                    stallF       = 1'b1;
                    flushD       = 1'b1;
                    stateNext    = DRAIN;
                    drainCntNext = DRAIN_INIT;
                end
            end
            DRAIN: begin
                stallF = 1'b1;
                flushD = 1'b1;
                // The halt edge already counted as the first drain edge.
                if (drainCnt <= DRAIN_CNT_W'(1)) begin
                    stateNext    = HALTED;
                    drainCntNext = '0;
                end else begin
                    drainCntNext = drainCnt - DRAIN_CNT_W'(1);
                end
            end
            HALTED: begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                halted = 1'b1;
            end
            default: begin
                stateNext    = RUN;
                drainCntNext = '0;
            end
        endcase
        if (rst) begin
            stallF  = 1'b0;
            stallD  = 1'b0;
            flushD  = 1'b0;
            flushE  = 1'b0;
            pc_selF = 1'b0;
            halted  = 1'b0;
        end
    end

    // Saturating counters; cycle_count freezes once the pipeline is halted.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if ((state != HALTED) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (stallInc && (stall_count != '1)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter HALT_INSTR, default 32'hFFFF_FFFF, instruction word that ends the program.
REQ-002 Parameter DRAIN_CYCLES, default 4, number of falling edges spent draining after a halt; legal range 1..15.
REQ-003 Port clk  input  1  pipeline clock; all state changes on its falling edge, as for the pipeline registers.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port instrD  input  32  instruction currently held in the decode register.
REQ-006 Port mem_to_reg_writeE  input  1  load in execute.
REQ-007 Port write_reg_addrE  input  5  destination register of the execute instruction.
REQ-008 Port branch_takenE  input  1  branchE AND zeroE.
REQ-009 Port stallF  output  1  hold pcF.
REQ-010 Port stallD  output  1  hold pcD/instrD.
REQ-011 Port flushD  output  1  load NOP (32'h0) into instrD.
REQ-012 Port flushE  output  1  clear all execute-stage control signals.
REQ-013 Port pc_selF  output  1  1 = load pc_branchE into pcF.
REQ-014 Port halted  output  1  program finished; pipeline frozen.
REQ-015 Port cycle_count  output  32  falling edges elapsed since reset, up to and including the halting edge.
REQ-016 Port stall_count  output  16  number of load-use stall cycles inserted.

Function
REQ-017 FSM states RUN, DRAIN, HALTED; state register and counters update on negedge clk.
REQ-018 rs/rt of instrD are bits [25:21] and [20:16]; load_use = mem_to_reg_writeE AND write_reg_addrE != 0 AND write_reg_addrE matches rs or rt of instrD.
REQ-019 RUN with branch_takenE=1: pc_selF=1, flushD=1, flushE=1, stallF=stallD=0; branch takes priority over load_use and halt.
REQ-020 RUN with load_use=1 and no branch: stallF=1, stallD=1, flushE=1 for exactly that cycle; stall_count increments on that edge.
REQ-021 RUN with instrD == HALT_INSTR and no branch: on that edge go to DRAIN, drain counter := DRAIN_CYCLES-1; in the same cycle stallF=1 and flushD=1.
REQ-022 Halt is checked only when load_use=0; a halt stalled behind a load is recognised the following cycle.
REQ-023 DRAIN: stallF=1, flushD=1, flushE=0, pc_selF=0; counter decrements each edge; when it reaches 0, go to HALTED on that edge.
REQ-024 DRAIN ignores branch_takenE and load_use, because instructions older than the halt always complete.
REQ-025 HALTED: stallF=stallD=1, flushD=flushE=1, pc_selF=0, halted=1; the state is terminal until rst.
REQ-026 All outputs except the counters are combinational from state and inputs.
REQ-027 cycle_count increments on every edge in RUN and DRAIN, freezes in HALTED, and saturates at 32'hFFFF_FFFF.
REQ-028 stall_count saturates at 16'hFFFF.
REQ-029 An X or Z on any input in HALTED has no effect on the outputs.

Reset
REQ-030 rst=1 forces state RUN, drain counter 0, cycle_count 0, stall_count 0 immediately, independent of clk.
REQ-031 During reset, stallF=stallD=flushD=flushE=pc_selF=halted=0.
REQ-032 rst asserted mid-DRAIN or in HALTED returns to RUN with no residual stall.

Structure
REQ-033 Shared package holds the state encodings (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), HALT_INSTR, and the NOP constant.
REQ-034 A sub-module hazard_detect is natural; it computes load_use combinationally from instrD and the execute-stage fields.
REQ-035 The FSM and the counters stay in pipeline_sequencer.

Verification
REQ-036 Load 1: mem_to_reg_writeE=1, write_reg_addrE=5, instrD rs=5 -> one cycle of stallF=stallD=flushE=1; stall_count 0->1.
REQ-037 Load 2: same as REQ-036 but write_reg_addrE=0 -> no stall; stall_count unchanged.
REQ-038 Branch with load: branch_takenE=1 together with load_use=1 -> pc_selF=flushD=flushE=1, stallF=0, stall_count unchanged.
REQ-039 Halt: instrD=32'hFFFF_FFFF at cycle 10 with DRAIN_CYCLES=4 -> DRAIN for edges 10-13, halted=1 after edge 13, cycle_count frozen at 14.
REQ-040 Branch over halt: halt in instrD with branch_takenE=1 -> stays in RUN, pc_selF=1, halted remains 0.
REQ-041 Reset in drain: rst pulsed mid-DRAIN between clock edges -> immediate RUN with counters 0; a normal run then follows after rst falls.
